// File: rtl/mvu_apb_csr_pkg.sv
// Shared definitions for the MVU APB CSR block: register indices, STATUS and
// IRQ bit positions, and the packed 112-bit job descriptor.
package mvu_apb_csr_pkg;

    // Register index taken from paddr[4:2].
    typedef enum logic [2:0] {
        REG_CTRL    = 3'd0,
        REG_WBASE   = 3'd1,
        REG_IBASE   = 3'd2,
        REG_OBASE   = 3'd3,
        REG_LEN     = 3'd4,
        REG_STATUS  = 3'd5,
        REG_DONECNT = 3'd6,
        REG_IRQ     = 3'd7
    } reg_idx_e;

    localparam int CTRL_PUSH_BIT    = 0;
    localparam int STATUS_FULL_BIT  = 4;
    localparam int STATUS_EMPTY_BIT = 5;
    localparam int STATUS_BUSY_BIT  = 6;
    localparam int STATUS_ERR_BIT   = 7;
    localparam int IRQ_IE_BIT       = 0;
    localparam int IRQ_IP_BIT       = 8;

    // One queued job as seen by the MVU core.
    typedef struct packed {
        logic [31:0] wbase;
        logic [31:0] ibase;
        logic [31:0] obase;
        logic [15:0] len;
    } job_desc_t;

    localparam int DESC_W = $bits(job_desc_t);

    // Assemble the STATUS read word from its fields.
    function automatic logic [31:0] status_word(input logic [3:0] level, input logic full,
                                                input logic empty, input logic busy,
                                                input logic err);
        logic [31:0] w;
        w = '0;
        w[3:0] = level;
        w[STATUS_FULL_BIT] = full;
        w[STATUS_EMPTY_BIT] = empty;
        w[STATUS_BUSY_BIT] = busy;
        w[STATUS_ERR_BIT] = err;
        return w;
    endfunction

endpackage

// File: rtl/mvu_apb_csr_if.sv
// APB3 bus bundle between the E203 requester and the MVU CSR completer.
// With MVU_APB_PSLVERR_EN defined the bundle also carries pslverr.
interface mvu_apb_csr_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
`ifdef MVU_APB_PSLVERR_EN
    logic          pslverr;

    modport master (output paddr, psel, penable, pwrite, pwdata, input prdata, pslverr);
    modport slave  (input paddr, psel, penable, pwrite, pwdata, output prdata, pslverr);
`else
    modport master (output paddr, psel, penable, pwrite, pwdata, input prdata);
    modport slave  (input paddr, psel, penable, pwrite, pwdata, output prdata);
`endif
endinterface

// File: rtl/mvu_job_fifo.sv
// Synchronous job FIFO, DEPTH entries of WIDTH bits. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module mvu_job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 112
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Entry storage, written at the tail.
    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and fill level; pointers wrap naturally since DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop) begin
                level_q <= level_q + LW'(1);
            end else if (do_pop && !do_push) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    assign rdata = mem[rd_ptr];
    assign level = level_q;
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

endmodule

// File: rtl/mvu_apb_csr.sv
// MVU APB3 CSR completer: job descriptor registers, job FIFO towards the MVU
// core, completion counter and level interrupt. Zero-wait-state bus.
// Optional feature macro MVU_APB_PSLVERR_EN adds the pslverr response.
module mvu_apb_csr
    import mvu_apb_csr_pkg::*;
#(
    parameter int            AW        = 32,
    parameter int            DW        = 32,
    parameter int            JOB_DEPTH = 4,
    parameter logic [AW-1:0] BASE_ADDR = 32'h1004_2000
) (
    input  logic         clk,
    input  logic         rst_n,
    mvu_apb_csr_if.slave apb,
    output logic         job_valid,
    input  logic         job_ready,
    output logic [31:0]  job_wbase,
    output logic [31:0]  job_ibase,
    output logic [31:0]  job_obase,
    output logic [15:0]  job_len,
    input  logic         job_done,
    output logic         irq
);
    localparam int LW = $clog2(JOB_DEPTH) + 1;

    logic          setup;
    logic          access;
    logic          wr;
    logic          base_hit;
    reg_idx_e      idx;
    logic          unused_paddr;
    logic          reg_wr;
    logic          push_req;
    logic          push_blocked;
    logic          push_ok;
    logic          push_drop;
    logic          pop;

    logic [31:0]   wbase_q;
    logic [31:0]   ibase_q;
    logic [31:0]   obase_q;
    logic [15:0]   len_q;
    logic          err_q;
    logic          busy_q;
    logic          ie_q;
    logic          ip_q;
    logic          irq_q;
    logic [3:0]    out_q;
    logic [3:0]    out_next;
    logic [15:0]   donecnt_q;
    logic [DW-1:0] rdata_mux;
    logic [DW-1:0] prdata_q;

    job_desc_t     tail_desc;
    job_desc_t     head_desc;
    logic [LW-1:0] fifo_level;
    logic          fifo_full;
    logic          fifo_empty;

    assign setup        = apb.psel & ~apb.penable;
    assign access       = apb.psel & apb.penable;
    assign wr           = access & apb.pwrite;
    assign base_hit     = (apb.paddr[AW-1:8] == BASE_ADDR[AW-1:8]);
    assign idx          = reg_idx_e'(apb.paddr[4:2]);
    assign unused_paddr = ^{apb.paddr[7:5], apb.paddr[1:0]};

    assign pop          = job_valid & job_ready;
    assign push_req     = wr & base_hit & (idx == REG_CTRL) & apb.pwdata[CTRL_PUSH_BIT];
    assign push_blocked = fifo_full & ~pop;
    assign push_ok      = push_req & ~push_blocked;
    assign push_drop    = push_req & push_blocked;

`ifdef MVU_APB_PSLVERR_EN
    logic ro_bad;
    logic pslverr_q;

    // STATUS only accepts bit 7 (err clear); anything else is a read-only violation.
    assign ro_bad = (idx == REG_STATUS) &&
                    ((apb.pwdata & ~(DW'(1) << STATUS_ERR_BIT)) != '0);
    assign reg_wr = wr & base_hit & ~ro_bad;

    // Error response is decided in SETUP and held through ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pslverr_q <= 1'b0;
        end else if (setup) begin
            pslverr_q <= ~base_hit |
                         (apb.pwrite & (ro_bad | ((idx == REG_CTRL) &
                                                  apb.pwdata[CTRL_PUSH_BIT] & fifo_full)));
        end
    end

    assign apb.pslverr = pslverr_q;
`else
    assign reg_wr = wr & base_hit;
`endif

    // Read data mux; unmatched base returns zero.
    // NOTE: always_comb assigns a default before any branch so no path can
    // leave the output unassigned and infer a latch.
    always_comb begin
        rdata_mux = '0;
        if (base_hit) begin
            case (idx)
                REG_CTRL:    rdata_mux = '0;
                REG_WBASE:   rdata_mux = wbase_q;
                REG_IBASE:   rdata_mux = ibase_q;
                REG_OBASE:   rdata_mux = obase_q;
                REG_LEN:     rdata_mux = {16'h0, len_q};
                REG_STATUS:  rdata_mux = status_word(4'(fifo_level), fifo_full,
                                                     fifo_empty, busy_q, err_q);
                REG_DONECNT: rdata_mux = {16'h0, donecnt_q};
                REG_IRQ: begin
                    rdata_mux[IRQ_IE_BIT] = ie_q;
                    rdata_mux[IRQ_IP_BIT] = ip_q;
                end
                default:     rdata_mux = '0;
            endcase
        end
    end

    // Read data is captured in SETUP and held until the next SETUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prdata_q <= '0;
        end else if (setup) begin
            prdata_q <= rdata_mux;
        end
    end

    assign apb.prdata = prdata_q;

    // Writable descriptor and interrupt-enable registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbase_q <= '0;
            ibase_q <= '0;
            obase_q <= '0;
            len_q   <= '0;
            ie_q    <= 1'b0;
        end else if (reg_wr) begin
            case (idx)
                REG_WBASE: wbase_q <= apb.pwdata[31:0];
                REG_IBASE: ibase_q <= apb.pwdata[31:0];
                REG_OBASE: obase_q <= apb.pwdata[31:0];
                REG_LEN:   len_q   <= apb.pwdata[15:0];
                REG_IRQ:   ie_q    <= apb.pwdata[IRQ_IE_BIT];
                default:   ;
            endcase
        end
    end

    // Sticky overflow flag: set by a dropped PUSH, cleared by writing STATUS bit 7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (push_drop) begin
            err_q <= 1'b1;
        end else if (reg_wr && idx == REG_STATUS && apb.pwdata[STATUS_ERR_BIT]) begin
            err_q <= 1'b0;
        end
    end

    // Saturating completion counter; a clear coinciding with job_done lands on 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            donecnt_q <= '0;
        end else if (reg_wr && idx == REG_DONECNT) begin
            donecnt_q <= job_done ? 16'd1 : 16'd0;
        end else if (job_done && donecnt_q != 16'hFFFF) begin
            donecnt_q <= donecnt_q + 16'd1;
        end
    end

    // Pending flag (set beats W1C) and the registered interrupt output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ip_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (job_done) begin
                ip_q <= 1'b1;
            end else if (reg_wr && idx == REG_IRQ && apb.pwdata[IRQ_IP_BIT]) begin
                ip_q <= 1'b0;
            end
            irq_q <= ie_q & ip_q;
        end
    end

    assign irq = irq_q;

    // Next outstanding-job count: +1 per dispatch, -1 per completion, saturating both ways.
    always_comb begin
        out_next = out_q;
        if (pop && !job_done) begin
            if (out_q != 4'hF) out_next = out_q + 4'd1;
        end else if (job_done && !pop) begin
            if (out_q != 4'h0) out_next = out_q - 4'd1;
        end
    end

    // Outstanding count and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            out_q <= out_next;
            if (pop) begin
                busy_q <= 1'b1;
            end else if (job_done && out_next == 4'h0) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign tail_desc = '{wbase: wbase_q, ibase: ibase_q, obase: obase_q, len: len_q};

    mvu_job_fifo #(
        .DEPTH (JOB_DEPTH),
        .WIDTH (DESC_W)
    ) u_job_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .pop   (pop),
        .wdata (tail_desc),
        .rdata (head_desc),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign job_valid = ~fifo_empty;
    assign job_wbase = head_desc.wbase;
    assign job_ibase = head_desc.ibase;
    assign job_obase = head_desc.obase;
    assign job_len   = head_desc.len;

endmodule

// File: tb/tb_mvu_apb_csr.sv
// Directed + randomized bench for mvu_apb_csr against a queue-based model.
module tb_mvu_apb_csr;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h1004_2000;
    localparam int O_CTRL = 0, O_WBASE = 1, O_IBASE = 2, O_OBASE = 3;
    localparam int O_LEN = 4, O_STATUS = 5, O_DONECNT = 6, O_IRQ = 7;

    typedef struct {
        logic [31:0] w;
        logic [31:0] i;
        logic [31:0] o;
        logic [15:0] l;
    } job_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_wbase;
    logic [31:0] job_ibase;
    logic [31:0] job_obase;
    logic [15:0] job_len;
    logic        job_done;
    logic        irq;

    int errors = 0;
    int checks = 0;

    // Reference model state
    job_t        q[$];
    logic [31:0] m_w, m_i, m_o;
    logic [15:0] m_l;
    logic [15:0] m_done;
    logic        m_err, m_ie, m_ip;
    int          m_out;

    mvu_apb_csr_if #(.AW(32), .DW(32)) apb ();

    mvu_apb_csr #(
        .AW        (32),
        .DW        (32),
        .JOB_DEPTH (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .apb       (apb),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_wbase (job_wbase),
        .job_ibase (job_ibase),
        .job_obase (job_obase),
        .job_len   (job_len),
        .job_done  (job_done),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: observed still running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int idx);
        return BASE + 32'(idx * 4);
    endfunction

    function automatic logic [31:0] status_exp();
        logic [31:0] s;
        s = 32'(q.size());
        if (q.size() == DEPTH) s = s | 32'h10;
        if (q.size() == 0)     s = s | 32'h20;
        if (m_out != 0)        s = s | 32'h40;
        if (m_err)             s = s | 32'h80;
        return s;
    endfunction

    function automatic logic [31:0] reg_exp(input int idx);
        case (idx)
            O_WBASE:   return m_w;
            O_IBASE:   return m_i;
            O_OBASE:   return m_o;
            O_LEN:     return {16'h0, m_l};
            O_STATUS:  return status_exp();
            O_DONECNT: return {16'h0, m_done};
            O_IRQ:     return {23'h0, m_ip, 7'h0, m_ie};
            default:   return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_w = '0; m_i = '0; m_o = '0; m_l = '0; m_done = '0;
        m_err = 1'b0; m_ie = 1'b0; m_ip = 1'b0; m_out = 0;
    endtask

    task automatic model_done();
        if (m_done != 16'hFFFF) m_done = m_done + 16'd1;
        m_ip = 1'b1;
        if (m_out > 0) m_out--;
    endtask

    task automatic model_pop();
        void'(q.pop_front());
        if (m_out < 15) m_out++;
    endtask

    // One full APB transfer; optionally assert job_ready/job_done for the ACCESS cycle.
    task automatic apb_xfer(input logic [31:0] addr, input logic [31:0] wdata, input bit wr,
                            input bit rdy_acc, input bit done_acc,
                            output logic [31:0] rdata, output logic slverr);
        apb.paddr = addr; apb.pwrite = wr; apb.pwdata = wdata;
        apb.psel = 1'b1; apb.penable = 1'b0;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        if (rdy_acc)  job_ready = 1'b1;
        if (done_acc) job_done = 1'b1;
        rdata = apb.prdata;
`ifdef MVU_APB_PSLVERR_EN
        slverr = apb.pslverr;
`else
        slverr = 1'b0;
`endif
        @(posedge clk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0; job_ready = 1'b0; job_done = 1'b0;
    endtask

    task automatic reg_wr(input int idx, input logic [31:0] d);
        logic [31:0] rd;
        logic        se;
        apb_xfer(addr_of(idx), d, 1'b1, 1'b0, 1'b0, rd, se);
        case (idx)
            O_WBASE:   m_w = d;
            O_IBASE:   m_i = d;
            O_OBASE:   m_o = d;
            O_LEN:     m_l = d[15:0];
            O_STATUS:  if (d[7]) m_err = 1'b0;
            O_DONECNT: m_done = '0;
            O_IRQ: begin
                m_ie = d[0];
                if (d[8]) m_ip = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic reg_rd(input int idx, output logic [31:0] d);
        logic se;
        apb_xfer(addr_of(idx), 32'h0, 1'b0, 1'b0, 1'b0, d, se);
`ifdef MVU_APB_PSLVERR_EN
        check("rd_slverr", 32'(se), 32'h0);
`endif
    endtask

    task automatic rd_check(input string tag, input int idx);
        logic [31:0] d;
        reg_rd(idx, d);
        check(tag, d, reg_exp(idx));
    endtask

    task automatic push_job(input job_t j, input bit rdy_acc);
        logic [31:0] rd;
        logic        se;
        bit          popped;
        bit          blocked;
        reg_wr(O_WBASE, j.w);
        reg_wr(O_IBASE, j.i);
        reg_wr(O_OBASE, j.o);
        reg_wr(O_LEN, {16'h0, j.l});
        popped  = rdy_acc && (q.size() != 0);
        blocked = (q.size() == DEPTH) && !popped;
        apb_xfer(addr_of(O_CTRL), 32'h1, 1'b1, rdy_acc, 1'b0, rd, se);
`ifdef MVU_APB_PSLVERR_EN
        if (!rdy_acc) check("push_slverr", 32'(se), 32'(blocked));
`else
        if (se !== 1'b0) check("push_slverr_absent", 32'(se), 32'h0);
`endif
        if (popped) model_pop();
        if (blocked) m_err = 1'b1;
        else q.push_back(j);
    endtask

    task automatic check_head(input string tag);
        check({tag, "_valid"}, 32'(job_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check({tag, "_wbase"}, job_wbase, q[0].w);
            check({tag, "_ibase"}, job_ibase, q[0].i);
            check({tag, "_obase"}, job_obase, q[0].o);
            check({tag, "_len"}, 32'(job_len), 32'(q[0].l));
        end
    endtask

    task automatic pulse_done();
        job_done = 1'b1;
        @(posedge clk); #1;
        job_done = 1'b0;
        model_done();
    endtask

    function automatic job_t rand_job();
        job_t j;
        j.w = $urandom(); j.i = $urandom(); j.o = $urandom(); j.l = 16'($urandom());
        return j;
    endfunction

    initial begin
        logic [31:0] d;
        logic        se;
        job_t        j;
        int          guard;

        apb.paddr = '0; apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.pwdata = '0;
        job_ready = 1'b0; job_done = 1'b0; rst_n = 1'b0;
        model_reset();
        #12;
        check("reset_prdata", apb.prdata, 32'h0);
        check("reset_valid", 32'(job_valid), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) rd_check($sformatf("reset_reg%0d", k), k);

        // Directed single job
        j.w = 32'h100; j.i = 32'h200; j.o = 32'h300; j.l = 16'd64;
        push_job(j, 1'b0);
        check_head("job1");
        rd_check("job1_status", O_STATUS);

        // MVU takes it
        job_ready = 1'b1;
        @(posedge clk); #1;
        job_ready = 1'b0;
        model_pop();
        check_head("job1_popped");
        rd_check("job1_status_busy", O_STATUS);

        // Overfill with random descriptors
        for (int k = 0; k < 5; k++) push_job(rand_job(), 1'b0);
        rd_check("fill_status", O_STATUS);
        check_head("fill");
        rd_check("fill_len_rb", O_LEN);
        rd_check("fill_obase_rb", O_OBASE);

        // Clear err, then push into a full FIFO while the MVU pops
        reg_wr(O_STATUS, 32'h80);
        rd_check("err_clear", O_STATUS);
        push_job(rand_job(), 1'b1);
        rd_check("pushpop_status", O_STATUS);
        check_head("pushpop");

        // Drain with random ready
        guard = 0;
        while (q.size() != 0 && guard < 64) begin
            bit r;
            check_head("drain");
            r = (guard >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
            job_ready = r;
            @(posedge clk); #1;
            job_ready = 1'b0;
            if (r) model_pop();
            guard++;
        end
        check_head("drained");
        rd_check("drained_status", O_STATUS);

        // Interrupt path
        reg_wr(O_IRQ, 32'h1);
        job_done = 1'b1;
        @(posedge clk); #1;
        job_done = 1'b0;
        model_done();
        check("irq_latency", 32'(irq), 32'h0);
        @(posedge clk); #1;
        check("irq_set", 32'(irq), 32'(m_ie & m_ip));
        pulse_done();
        rd_check("donecnt_two", O_DONECNT);
        rd_check("irq_reg_set", O_IRQ);
        reg_wr(O_IRQ, 32'h100);
        @(posedge clk); #1;
        check("irq_cleared", 32'(irq), 32'(m_ie & m_ip));
        rd_check("irq_reg_clr", O_IRQ);

        // W1C racing job_done: set wins
        reg_wr(O_IRQ, 32'h1);
        pulse_done();
        apb_xfer(addr_of(O_IRQ), 32'h101, 1'b1, 1'b0, 1'b1, d, se);
        m_ie = 1'b1;
        model_done();
        rd_check("ip_set_wins", O_IRQ);

        // DONECNT clear racing job_done lands on 1
        apb_xfer(addr_of(O_DONECNT), $urandom(), 1'b1, 1'b0, 1'b1, d, se);
        model_done();
        m_done = 16'd1;
        rd_check("donecnt_clr_race", O_DONECNT);
        reg_wr(O_DONECNT, 32'h0);
        rd_check("donecnt_clr", O_DONECNT);

        // Finish all outstanding jobs; one extra completion must not underflow
        guard = 0;
        while (m_out > 0 && guard < 16) begin
            pulse_done();
            guard++;
        end
        rd_check("busy_still_on_out0", O_STATUS);
        pulse_done();
        rd_check("busy_cleared", O_STATUS);
        rd_check("donecnt_final", O_DONECNT);

        // Base mismatch: reads zero, writes ignored
        apb_xfer(32'h2000_0004, 32'h0, 1'b0, 1'b0, 1'b0, d, se);
        check("mismatch_rd", d, 32'h0);
`ifdef MVU_APB_PSLVERR_EN
        check("mismatch_rd_slverr", 32'(se), 32'h1);
`endif
        apb_xfer(32'h2000_0004, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, d, se);
        rd_check("mismatch_wr_ignored", O_WBASE);

        // Reset during ACCESS with a queued job and irq high
        push_job(rand_job(), 1'b0);
        check("pre_rst_valid", 32'(job_valid), 32'(q.size() != 0));
        check("pre_rst_irq", 32'(irq), 32'(m_ie & m_ip));
        apb.paddr = addr_of(O_WBASE); apb.pwrite = 1'b0; apb.psel = 1'b1; apb.penable = 1'b0;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        job_done = 1'b1;
        check("pre_rst_prdata", apb.prdata, m_w);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_valid", 32'(job_valid), 32'(q.size() != 0));
        check("rst_irq", 32'(irq), 32'(m_ie & m_ip));
        check("rst_prdata", apb.prdata, reg_exp(O_CTRL));
        @(posedge clk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0; job_done = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) rd_check($sformatf("post_rst_reg%0d", k), k);
        check_head("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
